// File: rtl/bus_arbit_rr.sv
// Round-robin bus arbiter with a bounded hold time per owner.
// The one-hot grant, grant_id and rearb are all registered. grant_id also serves as the owner register.
module bus_arbit_rr #(
  parameter int N_MASTERS = 4,
  parameter int MAX_HOLD  = 8,
  localparam int ID_W     = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] req,
  output logic [N_MASTERS-1:0] grant,
  output logic [ID_W-1:0]      grant_id,
  output logic                 rearb
);

  localparam logic [7:0]           HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [N_MASTERS-1:0] GRANT_0   = {{(N_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    DEC_KEEP,
    DEC_SWITCH,
    DEC_PARK
  } dec_t;

  logic [7:0]      hold_cnt;
  logic [7:0]      hold_nxt;
  logic [ID_W-1:0] owner_nxt;
  logic [ID_W-1:0] rr_pick;
  logic            rr_hit;
  logic            others;
  logic [ID_W-1:0] cand [N_MASTERS];
  dec_t            dec;

  assign others = |(req & ~grant);

  // cand[k] is the index k positions after the current owner, wrapping around.
  always_comb begin
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      cand[k] = ID_W'((32'(grant_id) + k) % N_MASTERS);
    end
  end

  always_comb begin
    rr_pick = grant_id;
    rr_hit  = 1'b0;
    for (int unsigned k = 1; k < N_MASTERS; k++) begin
      if (!rr_hit && req[cand[k]]) begin
        rr_hit  = 1'b1;
        rr_pick = cand[k];
      end
    end
  end

  always_comb begin
    dec       = DEC_KEEP;
    hold_nxt  = hold_cnt;
    owner_nxt = grant_id;
    if (req == '0) begin
      dec      = DEC_PARK;
      hold_nxt = '0;
    end else if (req[grant_id] && ((hold_cnt < HOLD_LAST) || !others)) begin
      if (hold_cnt < HOLD_LAST) begin
        hold_nxt = hold_cnt + 8'd1;
      end
    end else begin
      // Either a release or a forced rotation; both reach here only while another master requests.
      dec       = DEC_SWITCH;
      owner_nxt = rr_pick;
      hold_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant    <= GRANT_0;
      grant_id <= '0;
      hold_cnt <= '0;
      rearb    <= 1'b0;
    end else begin
      grant    <= GRANT_0 << owner_nxt;
      grant_id <= owner_nxt;
      hold_cnt <= hold_nxt;
      rearb    <= (dec == DEC_SWITCH);
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot(grant));
  a_grant_id_match: assert property (@(posedge clk) disable iff (reset) grant == (GRANT_0 << grant_id));

endmodule

// File: tb/tb_bus_arbit_rr.sv
// Bench for bus_arbit_rr with N_MASTERS=4 and MAX_HOLD=4. Directed scenarios carry literal expectations.
// Randomized traffic is compared on every cycle against a behavioural arbiter model.
module tb_bus_arbit_rr;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         rearb;

  int passes = 0;
  int total  = 0;

  int m_owner = 0;
  int m_hold  = 0;
  bit m_rearb = 0;
  bit m_valid = 0;

  bus_arbit_rr #(.N_MASTERS(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req(req),
    .grant(grant), .grant_id(grant_id), .rearb(rearb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // The owner keeps the bus for at most MH cycles while others wait, then hands it to the next requester in ring order.
  task automatic arb_step(input int o, input int h, input logic [N-1:0] r,
                          output int no, output int nh, output bit nr);
    bit others = 0;
    no = o; nh = h; nr = 0;
    for (int i = 0; i < N; i++) if (i != o && r[i]) others = 1;
    if (r == 0) begin
      nh = 0;
    end else if (r[o] && (h < MH - 1 || !others)) begin
      nh = (h + 1 > MH - 1) ? MH - 1 : h + 1;
    end else begin
      for (int k = N - 1; k >= 1; k--) if (r[(o + k) % N]) no = (o + k) % N;
      nh = 0;
      nr = 1;
    end
  endtask

  always @(posedge clk) begin : model
    int no, nh;
    bit nr;
    if (reset) begin
      m_owner <= 0; m_hold <= 0; m_rearb <= 0; m_valid <= 1;
    end else begin
      arb_step(m_owner, m_hold, req, no, nh, nr);
      m_owner <= no; m_hold <= nh; m_rearb <= nr;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_grant", int'(grant), 1 << m_owner);
      chk("model_grant_id", int'(grant_id), m_owner);
      chk("model_rearb", int'(rearb), int'(m_rearb));
    end
  end

  task automatic cyc(input logic r, input logic [N-1:0] q);
    @(negedge clk);
    reset = r;
    req   = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] q;
    // Reset held with no requests
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'b0000);
      chk("rst_grant", int'(grant), 1);
      chk("rst_id", int'(grant_id), 0);
      chk("rst_rearb", int'(rearb), 0);
    end
    // A single requester wins one cycle after reset is released
    cyc(0, 4'b0100);
    chk("single_grant", int'(grant), 4);
    chk("single_id", int'(grant_id), 2);
    chk("single_rearb", int'(rearb), 1);
    cyc(0, 4'b0100);
    chk("single_hold_grant", int'(grant), 4);
    chk("single_hold_rearb", int'(rearb), 0);
    // Full contention rotates every MH cycles
    cyc(1, 4'b1111);
    chk("rot_start", int'(grant), 1);
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 4'b1111);
      chk("rot_grant", int'(grant), 1 << ((k / 4) % 4));
      chk("rot_rearb", int'(rearb), (k % 4 == 0) ? 1 : 0);
    end
    // Release search skips the owner and wraps from 3 back to 0
    cyc(1, 4'b0000);
    cyc(0, 4'b0100);
    cyc(0, 4'b1111);
    cyc(0, 4'b1011);
    chk("rel_grant", int'(grant), 8);
    chk("rel_id", int'(grant_id), 3);
    cyc(0, 4'b0011);
    chk("wrap_grant", int'(grant), 1);
    chk("wrap_rearb", int'(rearb), 1);
    // Park keeps the owner, then a new requester takes over
    cyc(1, 4'b0000);
    cyc(0, 4'b1000);
    cyc(0, 4'b0000);
    chk("park_grant", int'(grant), 8);
    chk("park_rearb", int'(rearb), 0);
    cyc(0, 4'b0010);
    chk("unpark_grant", int'(grant), 2);
    // A long solo hold saturates hold_cnt, so a newcomer forces rotation at once
    cyc(1, 4'b0000);
    for (int i = 0; i < 10; i++) cyc(0, 4'b0001);
    cyc(0, 4'b0011);
    chk("sat_grant", int'(grant), 2);
    // A reset pulse in mid-grant returns ownership to master 0 with a fresh hold budget
    cyc(1, 4'b0000);
    cyc(0, 4'b0100);
    cyc(0, 4'b0100);
    cyc(0, 4'b0100);
    cyc(1, 4'b1111);
    chk("midrst_grant", int'(grant), 1);
    chk("midrst_id", int'(grant_id), 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 4'b1111);
      chk("midrst_hold", int'(grant), (k < 4) ? 1 : 2);
    end
    // Random traffic with occasional resets
    q = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) q = 4'b0000;
      else if ($urandom_range(0, 1) == 0) q = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, q);
    end
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/bus_arbit_rr.md
BUS_ARBIT_RR -- requirements
Module: bus_arbit_rr

Parameters
REQ-001 The block SHALL provide parameter N_MASTERS, default 4, giving the number of requesting masters (legal range 2..16).
REQ-002 The block SHALL provide parameter MAX_HOLD, default 8, giving the maximum consecutive grant cycles of one master while another is requesting (legal range 2..255).
REQ-003 The block SHALL define ID_W = clog2(N_MASTERS) as a derived width.

Interface
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 req  input  N_MASTERS  per-master bus request, bit i belongs to master i; level-sensitive.
REQ-007 grant  output  N_MASTERS  registered one-hot grant; exactly one bit SHALL be 1 at all times.
REQ-008 grant_id  output  ID_W  registered binary index of the granted master, always consistent with grant.
REQ-009 rearb  output  1  registered one-cycle pulse, 1 in the first cycle of a new owner's grant.

Function
REQ-010 The block SHALL hold two state items: owner (ID_W bits) and hold_cnt (8 bits, saturating at MAX_HOLD-1).
REQ-011 Latency: grant, grant_id and rearb SHALL be registered, responding one clock after req is sampled, with no combinational path from req to any output.
REQ-012 Keep: if req[owner]=1 and (hold_cnt < MAX_HOLD-1 or no other req bit is 1), owner SHALL be unchanged and hold_cnt SHALL increment, saturating at MAX_HOLD-1.
REQ-013 Release: if req[owner]=0 and any other req bit is 1, the next owner SHALL be the first requesting index searching owner+1, owner+2, ..., wrapping modulo N_MASTERS; hold_cnt SHALL become 0.
REQ-014 Forced rotation: if req[owner]=1, hold_cnt = MAX_HOLD-1 and any other req bit is 1, the next owner SHALL be chosen by the REQ-013 search; hold_cnt SHALL become 0.
REQ-015 Under REQ-014 a continuously requesting master SHALL receive exactly MAX_HOLD consecutive grant cycles when contention exists.
REQ-016 Park: if req is all zeros, owner SHALL be unchanged and hold_cnt SHALL become 0.
REQ-017 The round-robin search SHALL exclude the current owner and SHALL wrap from N_MASTERS-1 to 0.
REQ-018 rearb SHALL be 1 in a cycle only if owner changed at the preceding edge; a keep or park SHALL give rearb=0.
REQ-019 req bits of masters that are not granted SHALL never change hold_cnt except through a switch.
REQ-020 With N_MASTERS=2, when owner 0 drops req while master 1 requests, the grant SHALL move to master 1 one cycle later.

Reset
REQ-021 While reset=1 at a clock edge, the block SHALL set owner=0, hold_cnt=0, grant=one-hot bit 0, grant_id=0 and rearb=0, regardless of req.
REQ-022 Reset SHALL take priority over every function rule, including a reset asserted mid-grant or mid-rotation.
REQ-023 The first arbitration decision after reset release SHALL start from owner 0 with hold_cnt 0.

Verification (N_MASTERS=4, MAX_HOLD=4)
REQ-024 Reset, req=0000, 3 cycles -> grant=0001, grant_id=0 and rearb=0 throughout.
REQ-025 After reset, req=0100 held -> one cycle later grant=0100, grant_id=2 and rearb=1 for that one cycle; grant then stays 0100.
REQ-026 After reset, req=1111 held for 20 cycles -> grant SHALL be:
- 0001 for 4 cycles
- then 0010 for 4 cycles
- then 0100 for 4 cycles
- then 1000 for 4 cycles
- then 0001
- rearb=1 on each change.
REQ-027 Owner 2, req 1111 changes to 1011 -> next cycle grant=1000, grant_id=3; with req=0011 the following owner change SHALL go to grant=0001 (wrap).
REQ-028 Owner 3, req changes to 0000 -> grant stays 1000 and rearb=0; then req=0010 -> next cycle grant=0010.
REQ-029 Owner 2 with hold_cnt=2, reset pulsed one cycle with req=1111 -> next cycle grant=0001 and grant_id=0; master 0 then holds for 4 cycles.
